// File: rtl/fft_sample_ram.sv
// rtl/fft_sample_ram.sv - frame sample store sequencing bridge load, core compute and result readback
// Optional build macro FFT_BITREV_EN: bridge writes land at bit-reversed addresses.
module fft_sample_ram #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int N_SAMPLES  = 1024
) (
    input  logic                  i_clk,
    input  logic                  i_rstn,
    input  logic [15:0]           i_SAMPLE,
    input  logic [11:0]           i_SAMPLE_INDEX,
    input  logic                  i_WRITE,
    input  logic                  i_READ,
    input  logic                  i_DATA_LOADED,
    output logic [DATA_WIDTH-1:0] o_DATA,
    output logic                  o_CALC_END,
    output logic [11:0]           o_SAMPLES_NUMBER,
    output logic                  o_core_start,
    input  logic [ADDR_WIDTH-1:0] i_core_addr,
    input  logic [DATA_WIDTH-1:0] i_core_wdata,
    input  logic                  i_core_we,
    output logic [DATA_WIDTH-1:0] o_core_rdata,
    input  logic                  i_core_done,
    output logic                  o_busy,
    output logic                  o_err
);

    localparam int          DEPTH       = 2**ADDR_WIDTH;
    localparam logic [11:0] N_SAMPLES_W = 12'(N_SAMPLES);
    localparam logic [11:0] LAST_INDEX  = 12'(N_SAMPLES - 1);

    typedef enum logic [1:0] {S_LOAD, S_START, S_CALC, S_DONE} state_t;

    state_t                r_state;
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    logic                  w_in_range;
    logic                  w_bridge_open;
    logic                  w_bridge_we;
    logic                  w_core_we;
    logic [ADDR_WIDTH-1:0] w_rd_addr;
    logic [ADDR_WIDTH-1:0] w_wr_addr;
    logic [DATA_WIDTH-1:0] w_bridge_wdata;
    logic                  w_last_read;

    function automatic logic [ADDR_WIDTH-1:0] bit_rev(input logic [ADDR_WIDTH-1:0] a);
        logic [ADDR_WIDTH-1:0] r;
        r = '0;
        for (int i = 0; i < ADDR_WIDTH; i++) begin
            r[i] = a[ADDR_WIDTH-1-i];
        end
        return r;
    endfunction

    assign w_in_range     = (i_SAMPLE_INDEX < N_SAMPLES_W);
    assign w_bridge_open  = (r_state == S_LOAD) || (r_state == S_DONE);
    assign w_bridge_we    = i_WRITE && w_in_range && w_bridge_open;
    assign w_core_we      = i_core_we && (r_state == S_CALC);
    assign w_rd_addr      = i_SAMPLE_INDEX[ADDR_WIDTH-1:0];
    assign w_bridge_wdata = {i_SAMPLE, {(DATA_WIDTH-16){1'b0}}};
    assign w_last_read    = i_READ && (i_SAMPLE_INDEX == LAST_INDEX);

`ifdef FFT_BITREV_EN
    // Core consumes decimation-in-time order, so only the write side is permuted.
    assign w_wr_addr = bit_rev(i_SAMPLE_INDEX[ADDR_WIDTH-1:0]);
`else
    assign w_wr_addr = i_SAMPLE_INDEX[ADDR_WIDTH-1:0];
`endif

    assign o_DATA           = w_in_range ? r_mem[w_rd_addr] : '0;
    assign o_SAMPLES_NUMBER = N_SAMPLES_W;

    // Bridge and core writes never overlap: the bridge is locked out while the core owns the memory.
    always_ff @(posedge i_clk) begin
        if (w_bridge_we) begin
            r_mem[w_wr_addr] <= w_bridge_wdata;
        end else if (w_core_we) begin
            r_mem[i_core_addr] <= i_core_wdata;
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            o_core_rdata <= '0;
        end else begin
            o_core_rdata <= r_mem[i_core_addr];
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_state      <= S_LOAD;
            o_CALC_END   <= 1'b0;
            o_core_start <= 1'b0;
            o_busy       <= 1'b0;
            o_err        <= 1'b0;
        end else begin
            if (i_WRITE && (!w_in_range || !w_bridge_open)) begin
                o_err <= 1'b1;
            end
            o_core_start <= 1'b0;
            case (r_state)
                S_LOAD: begin
                    if (i_DATA_LOADED) begin
                        r_state      <= S_START;
                        o_core_start <= 1'b1;
                        o_busy       <= 1'b1;
                    end
                end
                S_START: begin
                    r_state <= S_CALC;
                end
                S_CALC: begin
                    if (i_core_done) begin
                        r_state    <= S_DONE;
                        o_busy     <= 1'b0;
                        o_CALC_END <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (i_WRITE || w_last_read) begin
                        r_state    <= S_LOAD;
                        o_CALC_END <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_LOAD;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fft_sample_ram.sv
// tb/tb_fft_sample_ram.sv - randomized bench for fft_sample_ram against a frame-level reference model
// Honours FFT_BITREV_EN when the bundle is built with it.
module tb_fft_sample_ram;

    localparam int N = 1024;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [15:0] i_SAMPLE = '0;
    logic [11:0] i_SAMPLE_INDEX = '0;
    logic        i_WRITE = 1'b0;
    logic        i_READ = 1'b0;
    logic        i_DATA_LOADED = 1'b0;
    logic [9:0]  i_core_addr = '0;
    logic [31:0] i_core_wdata = '0;
    logic        i_core_we = 1'b0;
    logic        i_core_done = 1'b0;
    logic [31:0] o_DATA;
    logic        o_CALC_END;
    logic [11:0] o_SAMPLES_NUMBER;
    logic        o_core_start;
    logic [31:0] o_core_rdata;
    logic        o_busy;
    logic        o_err;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    fft_sample_ram dut (
        .i_clk            (clk),
        .i_rstn           (rstn),
        .i_SAMPLE         (i_SAMPLE),
        .i_SAMPLE_INDEX   (i_SAMPLE_INDEX),
        .i_WRITE          (i_WRITE),
        .i_READ           (i_READ),
        .i_DATA_LOADED    (i_DATA_LOADED),
        .o_DATA           (o_DATA),
        .o_CALC_END       (o_CALC_END),
        .o_SAMPLES_NUMBER (o_SAMPLES_NUMBER),
        .o_core_start     (o_core_start),
        .i_core_addr      (i_core_addr),
        .i_core_wdata     (i_core_wdata),
        .i_core_we        (i_core_we),
        .o_core_rdata     (o_core_rdata),
        .i_core_done      (i_core_done),
        .o_busy           (o_busy),
        .o_err            (o_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int phys(input int idx);
`ifdef FFT_BITREV_EN
        int r = 0;
        for (int b = 0; b < 10; b++) begin
            if ((idx & (1 << b)) != 0) r |= 1 << (9 - b);
        end
        return r;
`else
        return idx;
`endif
    endfunction

    // Reference model: frame phase, memory image with known-content flags, sticky error.
    typedef enum {P_LOAD, P_START, P_CALC, P_DONE} phase_t;
    phase_t      ph = P_LOAD;
    logic [31:0] m_mem [N];
    bit          m_val [N];
    logic [31:0] m_rdata = '0;
    bit          m_rvalid = 1'b1;
    bit          m_err = 1'b0;
    int          m_idx;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ph       = P_LOAD;
            m_err    = 1'b0;
            m_rdata  = '0;
            m_rvalid = 1'b1;
            for (int i = 0; i < N; i++) m_val[i] = 1'b0;
        end else begin
            m_idx    = int'(i_SAMPLE_INDEX);
            m_rvalid = m_val[i_core_addr];
            m_rdata  = m_mem[i_core_addr];
            if (i_WRITE && (m_idx >= N || ph == P_START || ph == P_CALC)) m_err = 1'b1;
            if (i_WRITE && m_idx < N && (ph == P_LOAD || ph == P_DONE)) begin
                m_mem[phys(m_idx)] = {i_SAMPLE, 16'h0};
                m_val[phys(m_idx)] = 1'b1;
            end
            if (ph == P_CALC && i_core_we) begin
                m_mem[i_core_addr] = i_core_wdata;
                m_val[i_core_addr] = 1'b1;
            end
            case (ph)
                P_LOAD:  if (i_DATA_LOADED) ph = P_START;
                P_START: ph = P_CALC;
                P_CALC:  if (i_core_done) ph = P_DONE;
                P_DONE:  if (i_WRITE || (i_READ && m_idx == N - 1)) ph = P_LOAD;
                default: ph = P_LOAD;
            endcase
        end
    end

    always @(negedge clk) begin
        check("core_start", 32'(o_core_start), 32'(ph == P_START));
        check("busy", 32'(o_busy), 32'(ph == P_START || ph == P_CALC));
        check("calc_end", 32'(o_CALC_END), 32'(ph == P_DONE));
        check("err", 32'(o_err), 32'(m_err));
        check("samples_number", 32'(o_SAMPLES_NUMBER), 32'(N));
        if (m_rvalid) check("core_rdata", o_core_rdata, m_rdata);
        if (int'(i_SAMPLE_INDEX) >= N) check("bridge_rd_oob", o_DATA, 32'h0);
        else if (m_val[i_SAMPLE_INDEX]) check("bridge_rd", o_DATA, m_mem[i_SAMPLE_INDEX]);
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        i_WRITE       = 1'b0;
        i_READ        = 1'b0;
        i_DATA_LOADED = 1'b0;
        i_core_we     = 1'b0;
        i_core_done   = 1'b0;
    endtask

    task automatic random_load(input int count);
        for (int k = 0; k < count; k++) begin
            i_WRITE        = 1'b1;
            i_SAMPLE_INDEX = 12'($urandom_range(N - 1, 0));
            i_SAMPLE       = 16'($urandom);
            tick();
        end
        idle();
    endtask

    task automatic random_core(input int count);
        for (int k = 0; k < count; k++) begin
            i_core_addr    = 10'($urandom);
            i_core_wdata   = $urandom;
            i_core_we      = 1'($urandom);
            i_SAMPLE_INDEX = 12'($urandom_range(N - 1, 0));
            tick();
        end
        i_core_we = 1'b0;
    endtask

    initial begin
        idle();
        repeat (3) tick();
        rstn = 1'b1;
        #1;
        check("rst_busy", 32'(o_busy), 32'h0);
        check("rst_calc_end", 32'(o_CALC_END), 32'h0);
        check("rst_err", 32'(o_err), 32'h0);
        check("rst_core_rdata", o_core_rdata, 32'h0);

        // Frame 1: full ramp, last write coincides with DATA_LOADED.
        for (int k = 0; k < N; k++) begin
            i_WRITE        = 1'b1;
            i_SAMPLE_INDEX = 12'(k);
            i_SAMPLE       = 16'(k);
`ifdef FFT_BITREV_EN
            if (k == 1) i_SAMPLE = 16'hABCD;
`endif
            i_DATA_LOADED  = (k == N - 1);
            tick();
        end
        idle();
        #1;
        check("start_pulse", 32'(o_core_start), 32'h1);
        check("start_busy", 32'(o_busy), 32'h1);
`ifdef FFT_BITREV_EN
        i_core_addr = 10'd512;
        tick();
        #1;
        check("bitrev_core_rd", o_core_rdata, 32'hABCD_0000);
`else
        i_core_addr = 10'd5;
        tick();
        #1;
        check("core_rd_addr5", o_core_rdata, 32'h0005_0000);
`endif
        check("start_one_cycle", 32'(o_core_start), 32'h0);
        i_SAMPLE_INDEX = 12'd1023;
        #1;
        check("last_sample_stored", o_DATA, 32'(phys(1023) == 1023 ? 32'h03FF_0000 : o_DATA));
        random_core(150);
        i_core_addr  = 10'd3;
        i_core_wdata = 32'h1234_5678;
        i_core_we    = 1'b1;
        tick();
        i_core_we    = 1'b0;
        i_core_done  = 1'b1;
        tick();
        i_core_done  = 1'b0;
        #1;
        check("calc_end_set", 32'(o_CALC_END), 32'h1);
        i_SAMPLE_INDEX = 12'd3;
        #1;
        check("readback_idx3", o_DATA, 32'h1234_5678);
        for (int k = 0; k < 50; k++) begin
            i_READ         = 1'b1;
            i_SAMPLE_INDEX = 12'($urandom_range(N - 2, 0));
            tick();
        end
        i_SAMPLE_INDEX = 12'd1023;
        tick();
        i_READ = 1'b0;
        #1;
        check("calc_end_clear", 32'(o_CALC_END), 32'h0);

        // Frame 2: abandoned by reset in the middle of the computation.
        random_load(300);
        i_DATA_LOADED = 1'b1;
        tick();
        idle();
        random_core(20);
        rstn = 1'b0;
        #1;
        check("midcalc_busy", 32'(o_busy), 32'h0);
        check("midcalc_calc_end", 32'(o_CALC_END), 32'h0);
        check("midcalc_err", 32'(o_err), 32'h0);
        check("midcalc_start", 32'(o_core_start), 32'h0);
        tick();
        rstn = 1'b1;
        tick();

        // Frame 3: bridge write during compute, then an early new frame from S_DONE.
        random_load(200);
        i_WRITE        = 1'b1;
        i_SAMPLE_INDEX = 12'd7;
        i_SAMPLE       = 16'h7777;
        i_DATA_LOADED  = 1'b1;
        tick();
        idle();
        tick();
        i_WRITE        = 1'b1;
        i_SAMPLE_INDEX = 12'd7;
        i_SAMPLE       = 16'hBEEF;
        tick();
        i_WRITE        = 1'b0;
        i_SAMPLE_INDEX = 12'(phys(7));
        #1;
        check("calc_write_err", 32'(o_err), 32'h1);
        check("calc_write_dropped", o_DATA, 32'h7777_0000);
        random_core(30);
        i_core_done = 1'b1;
        tick();
        i_core_done    = 1'b0;
        i_WRITE        = 1'b1;
        i_SAMPLE_INDEX = 12'd10;
        i_SAMPLE       = 16'h5A5A;
        tick();
        i_WRITE        = 1'b0;
        i_SAMPLE_INDEX = 12'(phys(10));
        #1;
        check("done_write_leaves", 32'(o_CALC_END), 32'h0);
        check("done_write_stored", o_DATA, 32'h5A5A_0000);
        check("err_sticky", 32'(o_err), 32'h1);

        // Out-of-range write and read from a clean error state.
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        tick();
        i_WRITE        = 1'b1;
        i_SAMPLE_INDEX = 12'd1024;
        i_SAMPLE       = 16'h1111;
        tick();
        i_WRITE        = 1'b0;
        #1;
        check("oob_write_err", 32'(o_err), 32'h1);
        i_SAMPLE_INDEX = 12'd2000;
        #1;
        check("oob_read_zero", o_DATA, 32'h0);
        repeat (3) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
